// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - ID-stage query/issue bundle for reg_scoreboard
//
// Purpose: groups the decoder-side operand query, the issue/flush request and
// the hazard controls returned to the PC and IF/ID registers.
// Signals:
//   rs_i, rt_i      source registers of the instruction in ID
//   issue_i         instruction leaves ID this cycle and writes issue_rd_i
//   issue_rd_i      destination register of the issuing instruction
//   issue_lat_i     cycles until the result is forwardable (0 = none)
//   flush_i         squash the instruction in ID
//   stall_o         operand not ready, insert bubble
//   pc_write_o      PC write enable
//   ifid_write_o    IF/ID write enable
//   busy_o          per-register in-flight flags
//   stall_cnt_o     saturating count of stall cycles
// master = ID-stage decoder side, slave = scoreboard side.
interface reg_scoreboard_if #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2,
  parameter int PERF_W   = 16
);
  logic [4:0]          rs_i;
  logic [4:0]          rt_i;
  logic                issue_i;
  logic [4:0]          issue_rd_i;
  logic [CNT_W-1:0]    issue_lat_i;
  logic                flush_i;
  logic                stall_o;
  logic                pc_write_o;
  logic                ifid_write_o;
  logic [NUM_REGS-1:0] busy_o;
  logic [PERF_W-1:0]   stall_cnt_o;

  modport master (
    output rs_i, rt_i, issue_i, issue_rd_i, issue_lat_i, flush_i,
    input  stall_o, pc_write_o, ifid_write_o, busy_o, stall_cnt_o
  );

  modport slave (
    input  rs_i, rt_i, issue_i, issue_rd_i, issue_lat_i, flush_i,
    output stall_o, pc_write_o, ifid_write_o, busy_o, stall_cnt_o
  );
endinterface

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - in-flight register write tracker with stall control
//
// Purpose: each accepted issue loads a per-register countdown with the
// instruction's result latency; an ID-stage instruction reading a register
// whose countdown is nonzero stalls the front end. A saturating counter
// records the number of stall cycles.
// Ports:
//   clk_i   clock, all state on the rising edge
//   rst_i   synchronous active-high reset
//   sb      reg_scoreboard_if.slave (query, issue, flush in; stall, PC/IF-ID
//           write enables, busy flags and stall count out)
module reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2,
  parameter int PERF_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  reg_scoreboard_if.slave  sb
);

  logic [NUM_REGS-1:0] busy;
  logic [31:0]         busy_ext;
  logic                stall;
  logic                eff_issue;
  logic [PERF_W-1:0]   stall_cnt;

  // Register 0 is hard-wired zero and never tracked.
  assign busy[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    logic [CNT_W-1:0] cnt;

    // A fresh issue overrides any countdown still running (WAW), otherwise
    // the countdown decrements to zero and stops there.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt <= '0;
      end else if (eff_issue && (sb.issue_rd_i == 5'(r))) begin
        cnt <= sb.issue_lat_i;
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end

    assign busy[r] = (cnt != '0);
  end

  // Widen to the 5-bit register index space so rs/rt can index directly.
  assign busy_ext = 32'(busy);

  assign stall = ((sb.rs_i != 5'd0) && busy_ext[sb.rs_i]) ||
                 ((sb.rt_i != 5'd0) && busy_ext[sb.rt_i]);

  // A stalled or squashed instruction does not issue; it re-presents later.
  assign eff_issue = sb.issue_i && !stall && !sb.flush_i &&
                     (sb.issue_rd_i != 5'd0) && (sb.issue_lat_i != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign sb.stall_o      = stall;
  assign sb.pc_write_o   = ~stall;
  assign sb.ifid_write_o = ~stall;
  assign sb.busy_o       = busy;
  assign sb.stall_cnt_o  = stall_cnt;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - scoreboard-checked bench for reg_scoreboard
module tb_reg_scoreboard;

  localparam int NUM_REGS = 32;
  localparam int CNT_W    = 2;
  localparam int PERF_W   = 4;
  localparam int PERF_MAX = (1 << PERF_W) - 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  reg_scoreboard_if #(.NUM_REGS(NUM_REGS), .CNT_W(CNT_W), .PERF_W(PERF_W)) sb_if ();

  reg_scoreboard #(.NUM_REGS(NUM_REGS), .CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .sb    (sb_if)
  );

  typedef struct {
    logic                stall;
    logic [NUM_REGS-1:0] busy;
    logic [PERF_W-1:0]   scnt;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  int total = 0;
  int bad   = 0;

  // Reference model: a register is busy during cycle c while ready_at > c.
  int ready_at[NUM_REGS];
  int cyc    = 0;
  int nstall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check("stall",      32'(sb_if.stall_o),      32'(mon_e.stall));
      check("pc_write",   32'(sb_if.pc_write_o),   32'(!mon_e.stall));
      check("ifid_write", 32'(sb_if.ifid_write_o), 32'(!mon_e.stall));
      check("busy",       32'(sb_if.busy_o),       32'(mon_e.busy));
      check("stall_cnt",  32'(sb_if.stall_cnt_o),  32'(mon_e.scnt));
    end
  end

  task automatic step(input bit r, input int rs, input int rt, input bit iss,
                      input int rd, input int lat, input bit fl, input bit chk);
    exp_t                e;
    logic [NUM_REGS-1:0] bz;
    bit                  st;
    rst               = r;
    sb_if.rs_i        = 5'(rs);
    sb_if.rt_i        = 5'(rt);
    sb_if.issue_i     = iss;
    sb_if.issue_rd_i  = 5'(rd);
    sb_if.issue_lat_i = CNT_W'(lat);
    sb_if.flush_i     = fl;
    for (int i = 0; i < NUM_REGS; i++) bz[i] = (i != 0) && (ready_at[i] > cyc);
    st = ((rs != 0) && bz[rs]) || ((rt != 0) && bz[rt]);
    e.stall = st;
    e.busy  = bz;
    e.scnt  = PERF_W'((nstall > PERF_MAX) ? PERF_MAX : nstall);
    if (chk) q.push_back(e);
    if (r) begin
      for (int i = 0; i < NUM_REGS; i++) ready_at[i] = 0;
      nstall = 0;
    end else begin
      if (st) nstall++;
      if (iss && !st && !fl && rd != 0 && lat != 0) ready_at[rd] = cyc + 1 + lat;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) ready_at[i] = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);

    // reset state with a query
    step(0, 3, 4, 0, 0, 0, 0, 1);

    // load-use: one bubble
    step(0, 0, 0, 1, 5, 1, 0, 1);
    step(0, 5, 0, 0, 0, 0, 0, 1);
    step(0, 5, 0, 0, 0, 0, 0, 1);
    idle(1);

    // register 0 and latency 0 never mark busy
    step(0, 0, 0, 1, 0, 3, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 7, 0, 0, 1);
    step(0, 7, 7, 0, 0, 0, 0, 1);
    idle(3);

    // WAW override shortens the countdown
    step(0, 0, 0, 1, 9, 3, 0, 1);
    step(0, 0, 0, 1, 9, 1, 0, 1);
    step(0, 0, 9, 0, 0, 0, 0, 1);
    step(0, 0, 9, 0, 0, 0, 0, 1);
    idle(3);

    // flush discards the issue
    step(0, 0, 0, 1, 6, 2, 1, 1);
    step(0, 6, 0, 0, 0, 0, 0, 1);
    // issue while stalled is discarded
    step(0, 0, 0, 1, 12, 3, 0, 1);
    step(0, 12, 0, 1, 13, 3, 0, 1);
    step(0, 13, 0, 0, 0, 0, 0, 1);
    idle(4);

    // flush together with stall
    step(0, 0, 0, 1, 14, 2, 0, 1);
    step(0, 14, 0, 1, 15, 2, 1, 1);
    idle(4);

    // saturation of the stall counter
    for (int i = 0; i < 28; i++) step(0, 10, 0, 1, 10, 3, 0, 1);
    idle(4);

    // reset mid-countdown
    step(0, 0, 0, 1, 11, 3, 0, 1);
    step(1, 11, 0, 0, 0, 0, 0, 1);
    step(0, 11, 0, 0, 0, 0, 0, 1);

    // randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(63) == 0,
           int'($urandom_range(7)), int'($urandom_range(7)),
           $urandom_range(1) == 1,
           int'($urandom_range(7)), int'($urandom_range(3)),
           $urandom_range(7) == 0, 1);
    end
    idle(2);

    repeat (3) @(posedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Tracks in-flight register writes for the pipelined CPU and answers source-operand readiness queries from the ID stage. It is the writer-side counterpart of load-use hazard detection. Each issued instruction marks its destination register busy for a programmable number of cycles. The block then drives stall, PC-write and IF/ID-write controls whenever a decoding instruction reads a busy register. It sits between the ID-stage decoder and the PC and IF/ID pipeline registers, and includes a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is hard-wired zero.
- CNT_W, 2, width of per-register countdown; max issue latency 2^CNT_W-1.
- PERF_W, 16, width of the stall-cycle performance counter.

Ports:
- clk_i  in  1  single clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- rs_i  in  5  ID-stage source register 1.
- rt_i  in  5  ID-stage source register 2.
- issue_i  in  1  ID-stage instruction leaves ID this cycle and writes a register.
- issue_rd_i  in  5  destination register of the issuing instruction.
- issue_lat_i  in  CNT_W  cycles until the result is forwardable; 0 means none, 1 means load.
- flush_i  in  1  squash the instruction currently in ID; its issue is discarded.
- stall_o  in/out: out  1  operand not ready; insert bubble into ID/EX.
- pc_write_o  out  1  PC write enable, equal to ~stall_o.
- ifid_write_o  out  1  IF/ID write enable, equal to ~stall_o.
- busy_o  out  NUM_REGS  bit r is set when cnt[r] is nonzero.
- stall_cnt_o  out  PERF_W  number of cycles with stall_o high, saturating.

## Operation
- State: cnt[r] (CNT_W bits) for r = 1..NUM_REGS-1. cnt[0] is constant 0.
- stall_o is combinational:
  - (rs_i != 0 and cnt[rs_i] != 0) or (rt_i != 0 and cnt[rt_i] != 0).
- Effective issue: eff_issue = issue_i and not stall_o and not flush_i and issue_rd_i != 0 and issue_lat_i != 0.
- Per-register update each edge, highest priority first:
  - rst_i: cnt[r] <= 0.
  - eff_issue and r == issue_rd_i: cnt[r] <= issue_lat_i. The new issue overrides the in-progress countdown, which is the WAW case.
  - cnt[r] != 0: cnt[r] <= cnt[r] - 1.
  - Otherwise cnt[r] holds.
- Counters never wrap below 0.
- stall_cnt_o:
  - rst_i: 0.
  - Else if stall_o and stall_cnt_o != all-ones: +1.
  - Otherwise holds; it saturates at 2^PERF_W-1.
- flush_i does not clear existing counters. Older in-flight instructions still complete.
- flush_i and stall_o together: no issue takes place, and stall_o is still driven from the current counters.

## Timing
- Reset values: every cnt = 0, stall_o = 0, pc_write_o = 1, ifid_write_o = 1, busy_o = 0, stall_cnt_o = 0.
- Query latency is 0: stall_o reflects the counters registered at the most recent edge.
- Issue with latency L accepted at edge t:
  - busy_o[rd] is high from t until edge t+L, which clears it.
  - A dependent instruction in ID during cycles t..t+L-1 stalls L cycles.
  - A load (L=1) therefore produces exactly one bubble.
- Reset asserted mid-countdown clears all state at the next edge. stall_o falls in the following cycle.
- The issue port is ignored during the cycle stall_o is high. The stalled instruction re-presents its issue after the stall.

## Test plan
- Reset, then query rs=3, rt=4 -> stall_o=0, pc_write_o=1, busy_o=0, stall_cnt_o=0.
- Load-use:
  - Issue rd=5, lat=1, then rs=5 in the next cycle -> stall_o=1 for exactly 1 cycle.
  - stall_cnt_o=1 afterwards.
  - busy_o[5] clears.
- Register 0 and latency 0:
  - Issue rd=0, lat=3 -> busy_o stays 0.
  - Issue rd=7, lat=0 -> no stall on rs=7.
- WAW override: issue rd=9, lat=3, then next cycle issue rd=9, lat=1 -> cnt[9]=1; rs=9 stalls 1 cycle, not 2.
- Flush and stalled issue:
  - flush_i=1 with issue rd=6, lat=2 -> busy_o[6]=0.
  - Issue presented while stall_o=1 -> discarded.
- Saturation and mid-run reset:
  - With PERF_W=4, hold a dependency for 20 stall cycles -> stall_cnt_o stops at 15.
  - rst_i mid-countdown -> all outputs at reset values one edge later.
